// File: rtl/sensor_poll_scheduler_if.sv
// Sensor-read and LCD-refresh request/done handshake bundle between the poll scheduler and the two bus masters.
// The scheduler owns the requests (master); the I2C reader and LCD refresher answer with done pulses (slave).
interface sensor_poll_scheduler_if;
    logic       rd_req;
    logic       rd_done;
    logic [7:0] rd_data;
    logic       lcd_req;
    logic       lcd_done;

    modport master (
        output rd_req,
        output lcd_req,
        input  rd_done,
        input  rd_data,
        input  lcd_done
    );

    modport slave (
        input  rd_req,
        input  lcd_req,
        output rd_done,
        output rd_data,
        output lcd_done
    );
endinterface

// File: rtl/sensor_poll_scheduler.sv
// Periodic sequencer: one sensor read, latch/classify, then one LCD refresh per period; define SENSOR_AVG_EN for a 4-tap average.
// Latency: rd_done at N -> sample and lcd_req at N+2; requests are levels held until done or TIMEOUT cycles, never overlapping.
module sensor_poll_scheduler #(
    parameter int         POLL_PERIOD = 100000,
    parameter int         TIMEOUT     = 5000,
    parameter logic [7:0] THRESH      = 8'd100
) (
    input  logic                    clk_1MHz,
    input  logic                    rst,
    input  logic                    i_enable,
    sensor_poll_scheduler_if.master bus,
    output logic [7:0]              o_sample,
    output logic                    o_sample_valid,
    output logic                    o_danger,
    output logic                    o_busy,
    output logic                    o_err_timeout,
    output logic [7:0]              o_err_count
);

    localparam int CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] LAST_TO  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_LATCH,
        S_LCD
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_period_cnt;
    logic          r_pend;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_rd_byte;
    logic [7:0]    r_sample;
    logic          r_sample_valid;
    logic          r_danger;
    logic          r_busy;
    logic          r_err_timeout;
    logic [7:0]    r_err_count;
    logic          r_rd_req;
    logic          r_lcd_req;

    logic          w_tick;
    logic          w_to_hit;
    logic          w_rd_ack;
    logic          w_lcd_ack;
    logic          w_timeout;
    logic          w_enter;
    logic [7:0]    w_new_sample;

    assign w_tick    = (r_state != S_IDLE) && (r_period_cnt == LAST_CNT);
    assign w_to_hit  = (r_to_cnt == LAST_TO);
    // A done pulse only counts while its own request is up.
    assign w_rd_ack  = r_rd_req && bus.rd_done;
    assign w_lcd_ack = r_lcd_req && bus.lcd_done;
    assign w_enter   = (w_next != r_state);

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_enable && !r_pend) begin
                    w_next = S_IDLE;
                end else if (w_tick || r_pend) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (w_rd_ack) begin
                    w_next = S_LATCH;
                end else if (w_to_hit) begin
                    w_next    = S_LCD;
                    w_timeout = 1'b1;
                end
            end
            S_LATCH: begin
                w_next = S_LCD;
            end
            S_LCD: begin
                if (w_lcd_ack) begin
                    w_next = S_WAIT;
                end else if (w_to_hit) begin
                    w_next    = S_WAIT;
                    w_timeout = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Period counter is free-running outside IDLE so the poll phase does not drift with handshake latency.
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            r_period_cnt <= '0;
            r_pend       <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_period_cnt <= '0;
            end else if (r_period_cnt == LAST_CNT) begin
                r_period_cnt <= '0;
            end else begin
                r_period_cnt <= r_period_cnt + CW'(1);
            end

            if ((w_next == S_READ) && (r_state != S_READ)) begin
                r_pend <= 1'b0;
            end else if (w_next == S_IDLE) begin
                r_pend <= 1'b0;
            end else if (w_tick && (r_state != S_WAIT)) begin
                r_pend <= 1'b1;
            end

            if (w_enter) begin
                r_to_cnt <= '0;
            end else if ((r_state == S_READ) || (r_state == S_LCD)) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            r_rd_req      <= 1'b0;
            r_lcd_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_count   <= 8'd0;
        end else begin
            r_rd_req      <= (w_next == S_READ);
            r_lcd_req     <= (w_next == S_LCD);
            r_busy        <= (w_next != S_IDLE) && (w_next != S_WAIT);
            r_err_timeout <= w_timeout;
            if (w_timeout && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            r_rd_byte      <= 8'd0;
            r_sample       <= 8'd0;
            r_sample_valid <= 1'b0;
            r_danger       <= 1'b0;
        end else begin
            if (w_rd_ack) begin
                r_rd_byte <= bus.rd_data;
            end
            if (r_state == S_LATCH) begin
                r_sample       <= w_new_sample;
                r_sample_valid <= 1'b1;
                r_danger       <= (w_new_sample > THRESH);
            end
        end
    end

`ifdef SENSOR_AVG_EN
    // Three stored taps plus the byte being latched form the 4-sample window.
    logic [7:0] r_tap0;
    logic [7:0] r_tap1;
    logic [7:0] r_tap2;
    logic [9:0] w_sum;

    always_comb begin
        w_sum = {r_rd_byte, 2'b00};
        if (r_sample_valid) begin
            w_sum = {2'b00, r_tap0} + {2'b00, r_tap1} + {2'b00, r_tap2} + {2'b00, r_rd_byte};
        end
    end

    assign w_new_sample = 8'(w_sum >> 2);

    always_ff @(posedge clk_1MHz or posedge rst) begin
        if (rst) begin
            r_tap0 <= 8'd0;
            r_tap1 <= 8'd0;
            r_tap2 <= 8'd0;
        end else if (r_state == S_LATCH) begin
            if (!r_sample_valid) begin
                r_tap0 <= r_rd_byte;
                r_tap1 <= r_rd_byte;
                r_tap2 <= r_rd_byte;
            end else begin
                r_tap0 <= r_tap1;
                r_tap1 <= r_tap2;
                r_tap2 <= r_rd_byte;
            end
        end
    end
`else
    assign w_new_sample = r_rd_byte;
`endif

    assign bus.rd_req     = r_rd_req;
    assign bus.lcd_req    = r_lcd_req;
    assign o_sample       = r_sample;
    assign o_sample_valid = r_sample_valid;
    assign o_danger       = r_danger;
    assign o_busy         = r_busy;
    assign o_err_timeout  = r_err_timeout;
    assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Self-checking bench for sensor_poll_scheduler: randomized handshake delays/data against a cycle-time model of the poll schedule.
module tb_sensor_poll_scheduler;
    localparam int         P  = 10;
    localparam int         T  = 24;
    localparam logic [7:0] TH = 8'd100;

    logic       clk_1MHz = 1'b0;
    logic       rst      = 1'b1;
    logic       enable   = 1'b0;
    logic [7:0] sample;
    logic [7:0] err_count;
    logic       sample_valid;
    logic       danger;
    logic       busy;
    logic       err_timeout;

    sensor_poll_scheduler_if bus ();

    sensor_poll_scheduler #(
        .POLL_PERIOD(P),
        .TIMEOUT    (T),
        .THRESH     (TH)
    ) dut (
        .clk_1MHz      (clk_1MHz),
        .rst           (rst),
        .i_enable      (enable),
        .bus           (bus),
        .o_sample      (sample),
        .o_sample_valid(sample_valid),
        .o_danger      (danger),
        .o_busy        (busy),
        .o_err_timeout (err_timeout),
        .o_err_count   (err_count)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         t0       = 0;
    int         exp_next = 0;
    logic [7:0] m_sample = 8'd0;
    logic [7:0] m_errcnt = 8'd0;
    bit         m_valid  = 1'b0;
    bit         noise    = 1'b0;
    int         taps[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_1MHz);
        cyc++;
    endtask

    // Ticks land every P cycles, the first one P-1 cycles after the counter origin t0.
    function automatic bit is_tick(int c);
        return (c >= t0) && (((c - t0) % P) == (P - 1));
    endfunction

    // READ window is [r, w-1]; any tick there leaves one pending poll, otherwise the next tick in WAIT starts it.
    function automatic int next_read(int r, int w);
        int n   = 0;
        int res = -2;
        for (int c = r; c < w; c++) begin
            if (is_tick(c)) n++;
        end
        if (n > 0) begin
            res = w + 1;
        end else if (!enable) begin
            res = -1;
        end else begin
            for (int c = w + P - 1; c >= w; c--) begin
                if (is_tick(c)) res = c + 1;
            end
        end
        return res;
    endfunction

    function automatic void accept(logic [7:0] b);
`ifdef SENSOR_AVG_EN
        int s = 0;
        if (!m_valid) begin
            taps.delete();
            repeat (4) taps.push_back(int'(b));
        end else begin
            void'(taps.pop_front());
            taps.push_back(int'(b));
        end
        foreach (taps[i]) s += taps[i];
        m_sample = 8'(s / 4);
`else
        m_sample = b;
`endif
        m_valid = 1'b1;
    endfunction

    task automatic reset_model();
        m_sample = 8'd0;
        m_errcnt = 8'd0;
        m_valid  = 1'b0;
        taps.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_req"},       bus.rd_req,   0);
        chk({tag, "_lcd_req"},      bus.lcd_req,  0);
        chk({tag, "_sample"},       sample,       0);
        chk({tag, "_sample_valid"}, sample_valid, 0);
        chk({tag, "_danger"},       danger,       0);
        chk({tag, "_busy"},         busy,         0);
        chk({tag, "_err_timeout"},  err_timeout,  0);
        chk({tag, "_err_count"},    err_count,    0);
    endtask

    task automatic bump_err();
        if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
    endtask

    task automatic do_poll(input int d, input int e, input bit rd_to, input bit lcd_to,
                           input logic [7:0] dat, input bit drop_en, input bit rst_in_lcd);
        int r;
        int l;
        int w;
        int cnt;
        cnt = 0;
        while ((bus.rd_req !== 1'b1) && (cnt < 3 * P + 2 * T)) begin
            if (noise) begin
                bus.rd_done  = 1'($urandom_range(0, 1));
                bus.rd_data  = 8'($urandom);
                bus.lcd_done = 1'($urandom_range(0, 1));
            end
            step();
            cnt++;
        end
        bus.rd_done  = 1'b0;
        bus.lcd_done = 1'b0;
        chk("rd_rise_cycle", cyc, exp_next);
        chk("busy_in_read", busy, 1);
        chk("lcd_req_in_read", bus.lcd_req, 0);
        r = cyc;
        if (drop_en) enable = 1'b0;

        if (!rd_to) begin
            repeat (d) step();
            bus.rd_done = 1'b1;
            bus.rd_data = dat;
            step();
            bus.rd_done = 1'b0;
            bus.rd_data = ~dat;
            chk("rd_req_fall", bus.rd_req, 0);
            chk("lcd_req_latch", bus.lcd_req, 0);
            bus.lcd_done = 1'b1;
            step();
            bus.lcd_done = 1'b0;
            accept(dat);
            chk("lcd_rise", bus.lcd_req, 1);
            chk("sample", sample, m_sample);
            chk("sample_valid", sample_valid, 1);
            chk("danger", danger, m_sample > TH);
        end else begin
            cnt = 0;
            while ((bus.rd_req === 1'b1) && (cnt < T + 4)) begin
                cnt++;
                step();
            end
            bump_err();
            chk("rd_req_len", cnt, T);
            chk("rd_to_pulse", err_timeout, 1);
            chk("rd_to_count", err_count, m_errcnt);
            chk("rd_to_lcd_req", bus.lcd_req, 1);
            chk("rd_to_sample", sample, m_sample);
            chk("rd_to_valid", sample_valid, m_valid);
        end
        l = cyc;

        if (rst_in_lcd) begin
            step();
            #2 rst = 1'b1;
            #1 chk_zero("async_rst");
            return;
        end

        if (!lcd_to) begin
            for (int k = 0; k < e; k++) begin
                step();
                if (k == 0) chk("err_pulse_once", err_timeout, 0);
            end
            bus.lcd_done = 1'b1;
            bus.rd_done  = noise;
            bus.rd_data  = ~m_sample;
            step();
            bus.lcd_done = 1'b0;
            bus.rd_done  = 1'b0;
            chk("lcd_req_fall", bus.lcd_req, 0);
            chk("busy_wait", busy, 0);
            chk("rd_req_wait", bus.rd_req, 0);
            chk("sample_hold", sample, m_sample);
        end else begin
            cnt = 0;
            while ((bus.lcd_req === 1'b1) && (cnt < T + 4)) begin
                cnt++;
                step();
                if (cnt == 1) chk("err_pulse_once", err_timeout, 0);
            end
            bump_err();
            chk("lcd_req_len", cnt, T);
            chk("lcd_to_pulse", err_timeout, 1);
            chk("lcd_to_count", err_count, m_errcnt);
            chk("lcd_to_busy", busy, 0);
        end
        w = cyc;
        exp_next = next_read(r, w);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [7:0] seq[4];
        bus.rd_done  = 1'b0;
        bus.rd_data  = 8'd0;
        bus.lcd_done = 1'b0;
        #1 chk_zero("reset");
        step();
        step();
        rst = 1'b0;
        enable = 1'b1;
        t0 = cyc + 1;
        exp_next = t0 + P;

        // Threshold boundary: 0x65 is dangerous, 0x64 equals THRESH and is not.
        do_poll(3, 2, 1'b0, 1'b0, 8'h65, 1'b0, 1'b0);
        do_poll(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'b0, 1'b0, 8'h64, 1'b0, 1'b0);

        noise = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_poll(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'b0, 1'b0,
                    8'($urandom), 1'b0, 1'b0);
        end

        do_poll(0, 1, 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        // Long LCD hold spans more than two periods: one pending poll, extra ticks dropped.
        do_poll(0, 21, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);
        do_poll(1, 1, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);
        do_poll(2, 0, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);
        do_poll(1, 0, 1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        do_poll(0, 0, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);

        do_poll(0, 0, 1'b0, 1'b0, 8'($urandom), 1'b1, 1'b0);
        for (int g = 0; (g < 4) && (exp_next >= 0); g++) begin
            do_poll(0, 0, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0);
        end
        chk("idle_model_reached", exp_next, 32'hFFFF_FFFF);
        cnt = 0;
        repeat (3 * P) begin
            step();
            if (bus.rd_req === 1'b1) cnt++;
        end
        chk("idle_no_rd_req", cnt, 0);
        chk("idle_busy", busy, 0);

        enable = 1'b1;
        t0 = cyc + 1;
        exp_next = t0 + P;
        do_poll(1, 1, 1'b0, 1'b0, 8'($urandom), 1'b0, 1'b1);
        step();
        chk_zero("held_rst");
        rst = 1'b0;
        bus.rd_done  = 1'b0;
        bus.lcd_done = 1'b0;
        reset_model();
        t0 = cyc + 1;
        exp_next = t0 + P;

        seq = '{8'h10, 8'h20, 8'h30, 8'h40};
        foreach (seq[i]) begin
            do_poll(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0,
                    seq[i], 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sensor_poll_scheduler.md
# sensor_poll_scheduler

Periodic sequencer between the sensor I2C read path and the LCD refresh path. Every poll period it requests one sensor byte, latches it and classifies it against a danger threshold. It then requests one LCD refresh and waits for completion, so sensor and LCD traffic never overlap. It replaces the tie-high request strapping at top level and supplies the latched sample and status flags used to build the LCD rows.

## Interface
- POLL_PERIOD, 100000 — poll interval in clk_1MHz cycles (100 ms); must be ≥ 2.
- TIMEOUT, 5000 — maximum cycles to wait for any done; must be ≥ 1.
- THRESH, 100 — danger threshold; the comparison is strictly greater-than, 8-bit unsigned.
- clk_1MHz  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new poll cycle starts; an in-flight cycle completes normally.
- rd_req  out  1  sensor read request, level.
- rd_done  in  1  sensor read complete; rd_data is valid in the same cycle.
- rd_data  in  8  sensor byte.
- lcd_req  out  1  LCD refresh request, level.
- lcd_done  in  1  LCD refresh complete.
- sample  out  8  last latched sample, or the filtered value when the filter is compiled in.
- sample_valid  out  1  sticky; set on the first successful latch.
- danger  out  1  registered result of sample > THRESH.
- busy  out  1  high in any state other than IDLE and WAIT.
- err_timeout  out  1  one-cycle pulse when a wait times out.
- err_count  out  8  timeout counter, saturates at 255.

## Operation
- States and transitions:
  - IDLE → WAIT when enable = 1.
  - WAIT → READ on tick, or immediately if pend = 1. WAIT → IDLE when enable = 0 and pend = 0.
  - READ → LATCH on rd_done; READ → LCD on timeout.
  - LATCH → LCD unconditionally.
  - LCD → WAIT on lcd_done or on timeout.
- Period counter:
  - Runs only while the state is not IDLE; counts 0..POLL_PERIOD-1 and wraps.
  - tick = (count == POLL_PERIOD-1).
  - A tick outside WAIT sets pend (a single bit). Further ticks while pend = 1 are dropped. pend clears on entry to READ.
- READ:
  - rd_req = 1. The timeout counter clears on entry and increments each cycle.
  - rd_done is sampled on the rising edge; the captured byte is rd_data from that cycle.
  - If the timeout counter reaches TIMEOUT-1 without rd_done: pulse err_timeout, increment err_count, keep sample unchanged, still refresh the LCD.
- LATCH: update sample, sample_valid = 1, and danger for the new sample.
- LCD: lcd_req = 1, with timeout handling identical to READ.
- Handshake rules:
  - req rises on state entry and falls in the cycle after done is sampled.
  - Done seen while the matching req is low is ignored.
  - rd_done and lcd_done asserting together affect only the active state.
- enable falling mid-cycle: the cycle finishes through LCD, then WAIT → IDLE. pend is cleared on IDLE entry.

## Timing
- Reset values:
  - state = IDLE, all counters = 0, pend = 0.
  - rd_req = lcd_req = 0.
  - sample = 0, sample_valid = danger = busy = err_timeout = 0, err_count = 0.
- All outputs are registered.
- First rd_req rises POLL_PERIOD cycles after IDLE exits (enable sampled high at cycle 0 → rd_req high at cycle POLL_PERIOD+1).
- rd_done at cycle N → sample updated at N+2 → lcd_req high at N+2.
- Minimum full cycle is 4 cycles: READ, LATCH, LCD, WAIT.
- Reset asserted mid-operation forces the reset values asynchronously. An in-flight I2C transaction is abandoned, and the I2C masters must reset on the same signal.

## Configuration
- SENSOR_AVG_EN defined:
  - sample = 4-tap moving average of the accepted bytes: (sum of the last 4) >> 2, with a 10-bit accumulator and truncation.
  - Taps are preloaded with the first accepted byte.
  - danger is computed on the averaged value.
- Undefined: sample = raw rd_data captured in READ, with no filter storage.

## Test plan
- POLL_PERIOD=10, enable=1, rd_done 3 cycles after rd_req with rd_data=0x65 → sample=0x65, danger=1, lcd_req rises exactly 2 cycles after rd_done.
- rd_data=0x64 → danger=0, since 100 is not greater than THRESH=100.
- TIMEOUT=8, rd_done never asserted → rd_req high for 8 cycles, err_timeout pulses once, err_count=1, sample unchanged, lcd_req still asserts.
- lcd_done held off past 2 tick periods → exactly one extra READ follows immediately after LCD completes, and the extra tick is dropped.
- enable deasserted during READ → the cycle completes through lcd_done, the FSM returns to IDLE, and there is no further rd_req.
- With SENSOR_AVG_EN, bytes 0x10, 0x20, 0x30, 0x40 → sample sequence 0x10, 0x14, 0x1C, 0x28. Reset mid-LCD → all outputs return to 0 immediately.
